// File: rtl/pic_pkg.sv
// Shared definitions for the PIC interrupt-acknowledge path: sequencer state
// encodings, the MCS-80 CALL opcode and the request-index width helper.
package pic_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACK1 = 3'd1;
  localparam logic [2:0] ST_ACK2 = 3'd2;
  localparam logic [2:0] ST_ACK3 = 3'd3;
  localparam logic [2:0] ST_POLL = 3'd4;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  localparam logic [1:0] SEL_CALL = 2'd0;
  localparam logic [1:0] SEL_LOW  = 2'd1;
  localparam logic [1:0] SEL_HIGH = 2'd2;

  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/intack_vector_gen.sv
// Combinational formation of the acknowledge bytes: CALL opcode, 8086 type
// byte, and the low/high bytes of the MCS-80 CALL target address.
module intack_vector_gen
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic                          mode_8086_i,
  input  logic                          interval_8_i,
  input  logic [15:0]                   vector_base_i,
  input  logic [idx_width(NUM_IRQ)-1:0] idx_i,
  input  logic [1:0]                    byte_sel_i,
  output logic [7:0]                    byte_o
);

  localparam int unsigned IDX_W = idx_width(NUM_IRQ);

  logic [15:0] call_mask;
  logic [15:0] target;
  logic [7:0]  type_byte;

  always_comb begin
    // Low address bits covered by the vector table are replaced by idx * interval.
    if (interval_8_i) begin
      call_mask = (16'd1 << (IDX_W + 3)) - 16'd1;
      target    = (vector_base_i & ~call_mask) | (16'(idx_i) << 3);
    end else begin
      call_mask = (16'd1 << (IDX_W + 2)) - 16'd1;
      target    = (vector_base_i & ~call_mask) | (16'(idx_i) << 2);
    end
    type_byte = (vector_base_i[7:0] & ~8'(NUM_IRQ - 1)) | 8'(idx_i);
    case (byte_sel_i)
      SEL_LOW:  byte_o = mode_8086_i ? type_byte : target[7:0];
      SEL_HIGH: byte_o = target[15:8];
      default:  byte_o = CALL_OPCODE;
    endcase
  end

endmodule

// File: rtl/intack_sequencer.sv
// Interrupt-acknowledge and poll-read sequencer: detects INTA/read strobes,
// latches the winning request and drives vector / CALL / poll bytes.
module intack_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          interrupt_acknowledge_n,
  input  logic                          read_n,
  input  logic                          u8086_mode,
  input  logic                          interval_8,
  input  logic                          aeoi_mode,
  input  logic [15:0]                   vector_base,
  input  logic                          cascade_drive,
  input  logic                          poll_cmd,
  input  logic                          irq_valid,
  input  logic [idx_width(NUM_IRQ)-1:0] irq_idx,
  output logic [7:0]                    data_out,
  output logic                          data_out_en,
  output logic                          isr_set,
  output logic [idx_width(NUM_IRQ)-1:0] isr_idx,
  output logic                          aeoi_pulse,
  output logic                          ack_busy
);

  localparam int unsigned IDX_W = idx_width(NUM_IRQ);

  logic [2:0]       state_q, state_d;
  logic             inta_prev_q, rd_prev_q;
  logic             inta_seen_q, rd_seen_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             spur_q, spur_d;
  logic             mode_q, mode_d;
  logic             int8_q, int8_d;
  logic             armed_q, armed_d;
  logic [7:0]       poll_byte_q, poll_byte_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             isr_set_q, isr_set_d;
  logic             aeoi_q, aeoi_d;
  logic [1:0]       byte_sel_d;
  logic [7:0]       vec_byte;
  logic             inta_low, inta_fall, inta_rise, rd_fall, rd_rise;

  // The seen flags keep a strobe that is still low across reset release from
  // being taken as a fresh falling edge.
  assign inta_low  = ~interrupt_acknowledge_n;
  assign inta_fall = inta_prev_q & inta_low & inta_seen_q;
  assign inta_rise = ~inta_prev_q & interrupt_acknowledge_n;
  assign rd_fall   = rd_prev_q & ~read_n & rd_seen_q;
  assign rd_rise   = ~rd_prev_q & read_n;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    spur_d      = spur_q;
    mode_d      = mode_q;
    int8_d      = int8_q;
    armed_d     = armed_q | poll_cmd;
    poll_byte_d = poll_byte_q;
    isr_set_d   = 1'b0;
    aeoi_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inta_fall) begin
          state_d   = ST_ACK1;
          idx_d     = irq_valid ? irq_idx : IDX_W'(NUM_IRQ - 1);
          spur_d    = ~irq_valid;
          mode_d    = u8086_mode;
          int8_d    = interval_8;
          isr_set_d = irq_valid;
        end else if (rd_fall && armed_q) begin
          state_d     = ST_POLL;
          armed_d     = 1'b0;
          poll_byte_d = irq_valid ? (8'h80 | 8'(irq_idx)) : 8'h00;
          isr_set_d   = irq_valid;
          if (irq_valid) idx_d = irq_idx;
        end
      end
      ST_ACK1: if (inta_fall) state_d = ST_ACK2;
      ST_ACK2: begin
        if (mode_q) begin
          if (inta_rise) begin
            state_d = ST_IDLE;
            aeoi_d  = aeoi_mode & ~spur_q;
          end
        end else if (inta_fall) begin
          state_d = ST_ACK3;
        end
      end
      ST_ACK3: begin
        if (inta_rise) begin
          state_d = ST_IDLE;
          aeoi_d  = aeoi_mode & ~spur_q;
        end
      end
      ST_POLL: if (rd_rise) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_sel_d = (state_d == ST_ACK3) ? SEL_HIGH :
                      (state_d == ST_ACK2) ? SEL_LOW  : SEL_CALL;

  intack_vector_gen #(.NUM_IRQ(NUM_IRQ)) u_vector_gen (
    .mode_8086_i  (mode_d),
    .interval_8_i (int8_d),
    .vector_base_i(vector_base),
    .idx_i        (idx_d),
    .byte_sel_i   (byte_sel_d),
    .byte_o       (vec_byte)
  );

  always_comb begin
    case (state_d)
      ST_ACK1:          en_d = ~mode_d & cascade_drive & inta_low;
      ST_ACK2, ST_ACK3: en_d = cascade_drive & inta_low;
      ST_POLL:          en_d = ~read_n;
      default:          en_d = 1'b0;
    endcase
    data_d = '0;
    if (en_d) data_d = (state_d == ST_POLL) ? poll_byte_d : vec_byte;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      inta_prev_q <= 1'b1;
      rd_prev_q   <= 1'b1;
      inta_seen_q <= 1'b0;
      rd_seen_q   <= 1'b0;
      idx_q       <= '0;
      spur_q      <= 1'b0;
      mode_q      <= 1'b0;
      int8_q      <= 1'b0;
      armed_q     <= 1'b0;
      poll_byte_q <= '0;
      data_q      <= '0;
      en_q        <= 1'b0;
      isr_set_q   <= 1'b0;
      aeoi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_prev_q <= interrupt_acknowledge_n;
      rd_prev_q   <= read_n;
      inta_seen_q <= inta_seen_q | interrupt_acknowledge_n;
      rd_seen_q   <= rd_seen_q | read_n;
      idx_q       <= idx_d;
      spur_q      <= spur_d;
      mode_q      <= mode_d;
      int8_q      <= int8_d;
      armed_q     <= armed_d;
      poll_byte_q <= poll_byte_d;
      data_q      <= data_d;
      en_q        <= en_d;
      isr_set_q   <= isr_set_d;
      aeoi_q      <= aeoi_d;
    end
  end

  assign data_out    = data_q;
  assign data_out_en = en_q;
  assign isr_set     = isr_set_q;
  assign isr_idx     = idx_q;
  assign aeoi_pulse  = aeoi_q;
  assign ack_busy    = (state_q != ST_IDLE);

endmodule
